// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Single-outstanding Wishbone B4 pipelined master. Converts a valid/ready
//   command into one bus cycle, retries on rty and returns a one-cycle
//   response pulse.
//
//   Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN
//     defined   -> 8-bit bus timeout counter aborts a cycle after TIMEOUT
//     undefined -> master waits indefinitely, rsp_timeout_o is constant 0
//
//   Ports
//     clk_i, rst_i               clock, synchronous active-high reset
//     req_valid_i / req_ready_o  command handshake (ready only in IDLE)
//     req_we_i, req_addr_i, req_sel_i, req_wdata_i   command fields
//     rsp_valid_o                one-cycle response pulse
//     rsp_rdata_o                read data, held until the next read ack
//     rsp_err_o, rsp_timeout_o   response status, qualified by rsp_valid_o
//     wb_*_o / wb_*_i            Wishbone master side
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a command
//   STROBE  | cyc=stb=1, waiting for stall to drop (or early termination)
//   WAIT    | cyc=1, stb=0, waiting for ack/err/rty
//   BACKOFF | one idle bus cycle before reissuing after rty
//   RESP    | rsp_valid_o pulse, bus idle

module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_RETRY  = 3,   // 0..255
  parameter int TIMEOUT    = 255  // 1..255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_sel_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT, S_BACKOFF, S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [3:0]            r_sel;
  logic [31:0]           r_dat;
  logic [7:0]            r_retry;
  logic [31:0]           r_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_tmo;

  logic w_accept, w_retry_inc, w_load_rsp, w_rsp_err, w_rsp_tmo, w_cap_rdata;
  logic w_timeout;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // Cleared whenever the bus is not in a cycle, so it restarts after BACKOFF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == S_STROBE || r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end else begin
      r_tmo_cnt <= 8'd0;
    end
  end

  // Counter is 0 in the first cyc cycle, so TIMEOUT-1 marks the last one.
  assign w_timeout = (r_tmo_cnt == 8'(TIMEOUT - 1));
`else
  logic [7:0] w_unused_tmo;
  assign w_unused_tmo = 8'(TIMEOUT);
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retry_inc = 1'b0;
    w_load_rsp  = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_tmo   = 1'b0;
    w_cap_rdata = 1'b0;
    req_ready_o = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = ~rst_i;
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE, S_WAIT: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = (r_state == S_STROBE);
        // err > ack > rty; a real termination beats a same-cycle timeout.
        if (wb_err_i) begin
          w_state_nxt = S_RESP;
          w_load_rsp  = 1'b1;
          w_rsp_err   = 1'b1;
        end else if (wb_ack_i) begin
          w_state_nxt = S_RESP;
          w_load_rsp  = 1'b1;
          w_cap_rdata = ~r_we;
        end else if (wb_rty_i) begin
          if (r_retry < 8'(MAX_RETRY)) begin
            w_state_nxt = S_BACKOFF;
            w_retry_inc = 1'b1;
          end else begin
            w_state_nxt = S_RESP;
            w_load_rsp  = 1'b1;
            w_rsp_err   = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_load_rsp  = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_tmo   = 1'b1;
        end else if (r_state == S_STROBE && !wb_stall_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_BACKOFF: w_state_nxt = S_STROBE;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_sel     <= 4'd0;
      r_dat     <= 32'd0;
      r_retry   <= 8'd0;
      r_rdata   <= 32'd0;
      r_rsp_err <= 1'b0;
      r_rsp_tmo <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we_i;
        r_adr   <= req_addr_i;
        r_sel   <= req_sel_i;
        r_dat   <= req_wdata_i;
        r_retry <= 8'd0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 8'd1;
      end
      if (w_load_rsp) begin
        r_rsp_err <= w_rsp_err;
        r_rsp_tmo <= w_rsp_tmo;
      end
      if (w_cap_rdata) begin
        r_rdata <= wb_dat_i;
      end
    end
  end

  assign wb_we_o       = r_we;
  assign wb_adr_o      = r_adr;
  assign wb_sel_o      = r_sel;
  assign wb_dat_o      = r_dat;
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_tmo;

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [3:0]  req_sel_i = 4'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;

  wb_cmd_master #(.ADDR_WIDTH(32), .MAX_RETRY(3), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  typedef struct { logic err; logic tmo; logic [31:0] rdata; } exp_t;
  exp_t exp_q[$];

  // slave configuration
  int   cfg_stall = 0, cfg_lat = 1, cfg_rty = 0;
  logic cfg_err = 1'b0, cfg_silent = 1'b0, cfg_ack_rty = 1'b0;
  int   sl_cnt = 0, sl_rty_done = 0;
  logic [31:0] mem [16];

  // bus observation
  int   stb_cnt = 0, rise_cnt = 0, rsp_cnt = 0, rsp_edge = 0, acc_edge = 0, base_rsp = 0;
  logic prev_cyc = 1'b0, bus_bad = 1'b0;
  logic        ex_we;
  logic [31:0] ex_adr, ex_dat;
  logic [3:0]  ex_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc_no++;
  end

  // register slave: stall for cfg_stall cycles, terminate cfg_lat cycles later
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    forever begin
      @(posedge clk_i); #1;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = 32'd0;
      if (wb_cyc_o !== 1'b1) begin
        sl_cnt = 0;
      end else begin
        wb_stall_i = (sl_cnt < cfg_stall);
        if (!cfg_silent && sl_cnt == cfg_stall + cfg_lat) begin
          if (sl_rty_done < cfg_rty) begin
            wb_rty_i = 1'b1;
            wb_ack_i = cfg_ack_rty;
            sl_rty_done++;
          end else begin
            wb_ack_i = 1'b1;
            wb_err_i = cfg_err;
          end
          if (wb_ack_i) begin
            wb_dat_i = mem[wb_adr_o[5:2]];
            if (wb_we_o && !wb_err_i && !wb_rty_i) mem[wb_adr_o[5:2]] = wb_dat_o;
          end
        end
        sl_cnt++;
      end
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk_i);
    if (wb_stb_o === 1'b1) stb_cnt++;
    if (wb_cyc_o === 1'b1 && !prev_cyc) rise_cnt++;
    prev_cyc = (wb_cyc_o === 1'b1);
    if (wb_cyc_o === 1'b1 &&
        {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== {ex_we, ex_adr, ex_sel, ex_dat})
      bus_bad = 1'b1;
    if (rsp_valid_o === 1'b1) begin
      rsp_edge = cyc_no;
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
        chk("rsp_timeout", {31'd0, rsp_timeout_o}, {31'd0, e.tmo});
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wd, input logic push, input logic e_err,
                       input logic e_tmo, input logic [31:0] e_rdata);
    int n = 0;
    while (req_ready_o !== 1'b1 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (req_ready_o !== 1'b1) chk("ready_wait", {31'd0, req_ready_o}, 32'd1);
    ex_we = we; ex_adr = adr; ex_sel = sel; ex_dat = wd;
    stb_cnt = 0; rise_cnt = 0; bus_bad = 1'b0; sl_rty_done = 0; base_rsp = rsp_cnt;
    if (push) exp_q.push_back('{e_err, e_tmo, e_rdata});
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = adr; req_sel_i = sel; req_wdata_i = wd;
    @(posedge clk_i); #1;
    acc_edge = cyc_no;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int e_lat, input int e_stb, input int e_rise);
    int n = 0;
    while (rsp_cnt == base_rsp && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({name, "_rsp_seen"}, 32'(rsp_cnt - base_rsp), 32'd1);
    chk({name, "_latency"}, 32'(rsp_edge + 1 - acc_edge), 32'(e_lat));
    chk({name, "_stb_cycles"}, 32'(stb_cnt), 32'(e_stb));
    chk({name, "_cyc_bursts"}, 32'(rise_cnt), 32'(e_rise));
    chk({name, "_bus_stable"}, {31'd0, bus_bad}, 32'd0);
    chk({name, "_ready_after"}, {31'd0, req_ready_o}, 32'd1);
    chk({name, "_cyc_idle"}, {31'd0, wb_cyc_o}, 32'd0);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_ready_low", {31'd0, req_ready_o}, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_ready_high", {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ready", {31'd0, req_ready_o}, 32'd0);
    chk("reset_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("reset_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    chk("reset_adr", wb_adr_o, 32'd0);
    chk("reset_err", {31'd0, rsp_err_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

    // write with stall held until the ack cycle
    cfg_stall = 2; cfg_lat = 0;
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd0);
    wait_rsp("wr_stall", 4, 3, 1);

    // read back from a 1-cycle-ack slave
    cfg_stall = 0; cfg_lat = 1;
    issue(1'b0, 32'h10, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    wait_rsp("rd_1cyc", 3, 1, 1);

    // stall 5 cycles, release without ack, ack 2 cycles later
    cfg_stall = 5; cfg_lat = 2;
    issue(1'b1, 32'h20, 4'hF, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    wait_rsp("stall5", 9, 6, 1);

    // two rty then ack
    cfg_stall = 0; cfg_lat = 1; cfg_rty = 2;
    issue(1'b1, 32'h24, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    wait_rsp("rty2", 9, 3, 3);

    cfg_rty = 0;
    issue(1'b0, 32'h24, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
    wait_rsp("rd_rty_data", 3, 1, 1);

    // retries exhausted: four rty -> error, read data untouched
    cfg_rty = 4;
    issue(1'b0, 32'h10, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
    wait_rsp("rty4", 12, 4, 4);

    // ack and rty together: ack wins
    cfg_rty = 1; cfg_ack_rty = 1'b1;
    issue(1'b0, 32'h20, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 32'h12345678);
    wait_rsp("ack_rty", 3, 1, 1);
    cfg_rty = 0; cfg_ack_rty = 1'b0;

    // err and ack together, terminated in the strobe cycle itself
    cfg_lat = 0; cfg_err = 1'b1;
    issue(1'b0, 32'h10, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0, 32'h12345678);
    wait_rsp("err_ack", 2, 1, 1);
    cfg_err = 1'b0; cfg_lat = 1;

    // silent slave
    cfg_silent = 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h30, 4'hF, 32'd0, 1'b1, 1'b1, 1'b1, 32'h12345678);
    wait_rsp("timeout", 17, 1, 1);
`else
    issue(1'b0, 32'h30, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc_o === 1'b1) hi++;
      @(posedge clk_i); #1;
    end
    chk("no_timeout_cyc_held", 32'(hi), 32'd1000);
    chk("no_timeout_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
    pulse_reset();
`endif

    // reset while waiting for a termination
    issue(1'b1, 32'h34, 4'h3, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    chk("wait_before_reset", {31'd0, wb_cyc_o & ~wb_stb_o}, 32'd1);
    pulse_reset();
    cfg_silent = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    chk("no_rsp_after_reset", 32'(rsp_cnt - base_rsp), 32'd0);

    issue(1'b0, 32'h24, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
    wait_rsp("post_reset", 3, 1, 1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
